data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Data-memory responder: the memory end of the CPU's load/store interface. The register file drives `loadEn`/`storEn`, an address and `storData`; this block returns `loadData`.
- Holds a single-port 8-bit data array behind a 2-entry posted store buffer.
- Loads have 1-cycle latency with store-to-load forwarding.
- `busy` back-pressures the CPU when a store cannot be accepted.

Parameters:
- ADDR_W, 8, address width; array depth = 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- start  in  1  synchronous active-high reset.
- loadEn  in  1  load request, sampled on posedge.
- storEn  in  1  store request, sampled on posedge.
- addr  in  ADDR_W  byte address for the request.
- storData  in  DATA_W  store data; may be Z when `storEn`=0 and must be ignored then.
- loadData  out  DATA_W  load result, valid when `ack`=1.
- ack  out  1  one-cycle pulse: `loadData` valid.
- busy  out  1  store buffer full; a store presented this cycle is not accepted.

Behaviour:
- Reset (`start`=1 at posedge):
  - `loadData`=0, `ack`=0, `busy`=0, store buffer count=0, FSM=IDLE.
  - Array contents are not reset.
  - Reset mid-operation discards buffered stores and any pending `ack`.
- Store buffer:
  - 2 entries {addr, data}, FIFO order, count 0..2.
  - `busy` is combinational: `busy` = (count==2).
- Store accept:
  - `storEn`=1 and count<2 at posedge: `addr`/`storData` are enqueued.
  - `storEn`=1 and count==2: not accepted. The CPU holds `storEn`/`addr`/`storData` until `busy` drops.
  - Accepting and draining in the same cycle is legal. Count is unchanged and order is preserved.
- Drain:
  - Each cycle with no load request and count>0, the oldest entry is written to the array and dequeued.
  - A load request has priority over drain for the array port.
- Load, FSM IDLE -> LRSP -> IDLE:
  - `loadEn`=1 in IDLE at cycle N: lookup uses `addr`.
  - At cycle N+1 the FSM is in LRSP, `ack`=1 and `loadData` holds the result. LRSP returns to IDLE the following cycle unless `loadEn` is asserted again.
  - Back-to-back loads: `loadEn` sampled in LRSP is also accepted, giving one result per cycle with `ack` held high.
- Result selection:
  - Youngest buffered entry with a matching address.
  - Else an entry being drained this cycle, if its address matches.
  - Else the array read.
- Simultaneous `loadEn`+`storEn`:
  - The load is serviced against state before the store; it does not see the same-cycle store.
  - The store is enqueued if count<2.
- `loadData` holds its last value when `ack`=0.
- Address wrap: addresses are modulo 2**ADDR_W; no bounds error.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: forwarding from the store buffer as described above. Loads never stall.
- Undefined: no forwarding.
  - A load whose address matches any buffered entry is held off. `busy` asserts and `ack` stays 0 until the matching entries have drained; the CPU holds `loadEn`/`addr`.
  - Non-matching loads behave as with the macro defined.
  - Used to save area and to cross-check ordering.

Test Plan:
- Reset then load addr 0x10 -> `ack`=1 at N+1; `loadData` is the array contents. All outputs 0 during reset.
- Store 0xA5 to 0x20, then load 0x20 next cycle -> `loadData`=0xA5 at N+1, via forwarding or, without STORE_FWD_EN, after the stall.
- Three stores on back-to-back cycles while loads block drain -> `busy`=1 on the third; it is accepted after the first drain. Final array: 0x30=0x01, 0x31=0x02, 0x32=0x03.
- Two stores to 0x40 (0x11, then 0x22) both buffered, load 0x40 -> `loadData`=0x22 (youngest wins).
- Same-cycle `loadEn`+`storEn`, addr 0x50 (old 0x00), store 0x77 -> `loadData`=0x00. A following load returns 0x77.
- `start` asserted with 2 buffered stores -> buffer empty, `busy`=0. A later load of those addresses returns the pre-store array values.

Source files
------------

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-port data array behind a 2-entry posted store buffer.
// Loads complete one cycle after they are accepted. A load takes the array port ahead
// of the buffer drain.
// Optional feature macro: STORE_FWD_EN. When it is defined, loads are forwarded from the
// store buffer. When it is undefined, a load whose address hits the buffer waits, with
// busy asserted, until the matching entries have drained.
module data_mem_resp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              start,
  input  logic              loadEn,
  input  logic              storEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storData,
  output logic [DATA_W-1:0] loadData,
  output logic              ack,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StLrsp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] buf_addr_q [2];
  logic [ADDR_W-1:0] buf_addr_d [2];
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              hit0, hit1;
  logic              load_stall, load_go, store_go, drain;
  logic [DATA_W-1:0] load_result;

  // Request decode: address hits, load acceptance, store acceptance and drain slot.
  always_comb begin
    hit0 = (count_q != 2'd0) && (buf_addr_q[0] == addr);
    hit1 = (count_q == 2'd2) && (buf_addr_q[1] == addr);
`ifdef STORE_FWD_EN
    load_stall = 1'b0;
`else
    // Without forwarding, a load must wait until the buffer no longer holds its address.
    load_stall = loadEn & (hit0 | hit1);
`endif
    load_go  = loadEn & ~load_stall;
    busy     = (count_q == 2'd2) | load_stall;
    store_go = storEn & ~busy;
    // The array port is free only when no load uses it this cycle.
    drain    = ~load_go & (count_q != 2'd0);
  end

  // Load result. The youngest matching entry wins. A drain never coincides with an
  // accepted load, so the buffer and the array together give the complete picture.
  always_comb begin
`ifdef STORE_FWD_EN
    if (hit1) begin
      load_result = buf_data_q[1];
    end else if (hit0) begin
      load_result = buf_data_q[0];
    end else begin
      load_result = mem_q[addr];
    end
`else
    load_result = mem_q[addr];
`endif
  end

  // FSM next state: every accepted load produces a response cycle in StLrsp.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = load_go ? StLrsp : StIdle;
      StLrsp:  state_d = load_go ? StLrsp : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load data register. It holds its value between responses.
  always_comb begin
    load_data_d = load_data_q;
    if (load_go) begin
      load_data_d = load_result;
    end
  end

  // Store buffer next state. Entry 0 is the oldest. The buffer dequeues on a drain and
  // enqueues at the first free slot left after the dequeue.
  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (drain) begin
      buf_addr_d[0] = buf_addr_q[1];
      buf_data_d[0] = buf_data_q[1];
    end
    if (store_go) begin
      if ((count_q == 2'd1) && !drain) begin
        buf_addr_d[1] = addr;
        buf_data_d[1] = storData;
      end else begin
        buf_addr_d[0] = addr;
        buf_data_d[0] = storData;
      end
    end
    count_d = count_q + {1'b0, store_go} - {1'b0, drain};
  end

  // Control and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (start) begin
      state_q     <= StIdle;
      count_q     <= 2'd0;
      load_data_q <= '0;
      buf_addr_q  <= '{default: '0};
      buf_data_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      load_data_q <= load_data_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Data array write port. The array is not reset, and reset discards pending drains.
  always_ff @(posedge clk) begin
    if (!start && drain) begin
      mem_q[buf_addr_q[0]] <= buf_data_q[0];
    end
  end

  assign ack      = (state_q == StLrsp);
  assign loadData = load_data_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp. The reference model is a program-order memory: a
// committed-array image plus a FIFO of posted stores. Each cycle is judged by the
// acceptance, drain and forwarding rules. The bench runs directed scenarios first and
// then random traffic on a small address window.
module tb_data_mem_resp;

  logic       clk = 1'b0;
  logic       start, loadEn, storEn;
  logic [7:0] addr, storData;
  logic [7:0] loadData;
  logic       ack, busy;

  data_mem_resp #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .start    (start),
    .loadEn   (loadEn),
    .storEn   (storEn),
    .addr     (addr),
    .storData (storData),
    .loadData (loadData),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference state.
  logic [7:0] phys [256];
  logic [7:0] qa [$];
  logic [7:0] qd [$];
  logic       exp_ack;
  logic [7:0] exp_ld;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus. The model is consulted before the edge and updated
  // after it.
  task automatic step(input logic rst, input logic le, input logic se,
                      input logic [7:0] a, input logic [7:0] d,
                      output logic ld_go, output logic st_go);
    logic       match, stall, m_busy, do_drain;
    logic [7:0] val;
    @(negedge clk);
    start = rst; loadEn = le; storEn = se; addr = a; storData = d;
    #1;
    match = 1'b0;
    val   = phys[a];
    for (int i = 0; i < qa.size(); i++) begin
      if (qa[i] == a) begin
        match = 1'b1;
        val   = qd[i];  // later entries are younger
      end
    end
`ifdef STORE_FWD_EN
    stall = 1'b0;
`else
    stall = le && match;
`endif
    m_busy   = (qa.size() == 2) || stall;
    ld_go    = le && !stall;
    st_go    = se && !m_busy;
    do_drain = !ld_go && (qa.size() > 0) && !rst;
    check("busy", {7'd0, busy}, {7'd0, m_busy});
    @(posedge clk);
    #1;
    if (rst) begin
      qa.delete(); qd.delete();
      exp_ack = 1'b0; exp_ld = 8'h00; ld_go = 1'b0; st_go = 1'b0;
    end else begin
      if (do_drain) begin
        phys[qa[0]] = qd[0];
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (st_go) begin
        qa.push_back(a);
        qd.push_back(d);
      end
      exp_ack = ld_go;
      if (ld_go) exp_ld = val;
    end
    check("ack", {7'd0, ack}, {7'd0, exp_ack});
    check("loadData", loadData, exp_ld);
  endtask

  task automatic idle(input int n);
    logic lg, sg;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'($urandom), lg, sg);
  endtask

  task automatic do_reset();
    logic lg, sg;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, lg, sg);
  endtask

  // Hold a load until it is accepted, within a bounded number of cycles.
  task automatic load_hold(input logic [7:0] a);
    logic lg, sg;
    int   n = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, a, 8'($urandom), lg, sg);
      n++;
    end while (!lg && n < 8);
    if (!lg) begin
      checks++; errors++;
      $error("FAIL load_timeout: addr 0x%0h observed not accepted expected accepted", a);
    end
  endtask

  // Hold a store until it is accepted. The first cycle can carry a load of the same
  // address; retries drop the load so that the buffer can drain.
  task automatic store_hold(input logic [7:0] a, input logic [7:0] d, input logic le);
    logic lg, sg;
    int   n = 0;
    step(1'b0, le, 1'b1, a, d, lg, sg);
    while (!sg && n < 8) begin
      step(1'b0, 1'b0, 1'b1, a, d, lg, sg);
      n++;
    end
    if (!sg) begin
      checks++; errors++;
      $error("FAIL store_timeout: addr 0x%0h observed not accepted expected accepted", a);
    end
  endtask

  initial begin
    logic lg, sg;
    start = 1'b1; loadEn = 1'b0; storEn = 1'b0; addr = '0; storData = '0;
    exp_ack = 1'b0; exp_ld = 8'h00;
    for (int i = 0; i < 256; i++) phys[i] = 8'h00;
    repeat (2) @(posedge clk);

    // Reset state: all outputs low.
    do_reset();

    // Fill the array through the store path so that every address has a known value.
    for (int i = 0; i < 256; i++) begin
      store_hold(8'(i), (i == 8'h50) ? 8'h00 : 8'($urandom), 1'b0);
    end
    idle(3);

    // The array survives reset. Load 0x10 afterwards.
    do_reset();
    load_hold(8'h10);
    idle(1);

    // Store, then load the same address immediately.
    store_hold(8'h20, 8'hA5, 1'b0);
    load_hold(8'h20);
    idle(3);

    // Three back-to-back stores while loads occupy the port. The third one sees busy.
    store_hold(8'h30, 8'h01, 1'b1);
    store_hold(8'h31, 8'h02, 1'b1);
    store_hold(8'h32, 8'h03, 1'b1);
    idle(3);
    load_hold(8'h30);
    load_hold(8'h31);
    load_hold(8'h32);
    idle(2);

    // Two stores to one address. The youngest must win.
    store_hold(8'h40, 8'h11, 1'b1);
    store_hold(8'h40, 8'h22, 1'b1);
    load_hold(8'h40);
    idle(3);

    // Same-cycle load and store. The load sees the old value; a later load sees the new one.
    step(1'b0, 1'b1, 1'b1, 8'h50, 8'h77, lg, sg);
    load_hold(8'h50);
    idle(3);

    // Reset while two stores are buffered. Both stores are discarded.
    step(1'b0, 1'b1, 1'b1, 8'h60, 8'hC3, lg, sg);
    step(1'b0, 1'b1, 1'b1, 8'h61, 8'h3C, lg, sg);
    do_reset();
    idle(1);
    load_hold(8'h60);
    load_hold(8'h61);
    idle(2);

    // Random traffic on a narrow window so that hits, stalls and full buffers are common.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) == 0, 1'($urandom), 1'($urandom),
           8'h70 + 8'($urandom % 4), 8'($urandom), lg, sg);
    end
    idle(3);
    for (int i = 0; i < 4; i++) load_hold(8'h70 + 8'(i));
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
